sumador_2bits: RTL and testbench



---
 rtl/sumador_2bits.sv | 87 ++++++++
 tb/tb_sumador_2bits.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/sumador_2bits.sv
// Half adder built from XOR/AND gate primitives, with an optional output register stage
// and a saturating count of accepted samples that produce a carry.
module sumador_2bits #(
  parameter bit REG_OUT = 1'b1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             B,
  input  logic             in_valid,
  output logic             S,
  output logic             C,
  output logic [1:0]       SUM,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_cnt
);

  logic s_n;
  logic c_n;

  xor u_xor (s_n, A, B);
  and u_and (c_n, A, B);

  logic [CNT_W-1:0] carry_cnt_q;
  logic [CNT_W-1:0] carry_cnt_d;

  // Stops at all-ones instead of wrapping back to zero.
  always_comb begin
    carry_cnt_d = carry_cnt_q;
    if (in_valid && c_n && (carry_cnt_q != {CNT_W{1'b1}})) begin
      carry_cnt_d = carry_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_cnt_q <= '0;
    end else begin
      carry_cnt_q <= carry_cnt_d;
    end
  end

  assign carry_cnt = carry_cnt_q;

  generate
    if (REG_OUT) begin : g_reg
      logic s_q, s_d;
      logic c_q, c_d;
      logic out_valid_q, out_valid_d;

      always_comb begin
        s_d         = s_q;
        c_d         = c_q;
        out_valid_d = in_valid;
        if (in_valid) begin
          s_d = s_n;
          c_d = c_n;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s_q         <= 1'b0;
          c_q         <= 1'b0;
          out_valid_q <= 1'b0;
        end else begin
          s_q         <= s_d;
          c_q         <= c_d;
          out_valid_q <= out_valid_d;
        end
      end

      assign S         = s_q;
      assign C         = c_q;
      assign out_valid = out_valid_q;
    end else begin : g_comb
      // Reset still forces the outputs low so both variants look identical while held in reset.
      assign S         = s_n & ~rst;
      assign C         = c_n & ~rst;
      assign out_valid = in_valid & ~rst;
    end
  endgenerate

  assign SUM = {C, S};

endmodule

// File: tb/tb_sumador_2bits.sv
// Scoreboard bench for sumador_2bits: registered instance checked through an expected-value
// queue drained by a monitor, plus a combinational instance checked directly.
module tb_sumador_2bits;

  logic       clk;
  logic       rst;
  logic       A, B, in_valid;
  logic       S, C, out_valid;
  logic [1:0] SUM;
  logic [7:0] carry_cnt;

  logic       a0, b0, v0;
  logic       s0, c0, ov0;
  logic [1:0] sum0;
  logic [7:0] cnt0;

  int n_checks;
  int n_fail;

  logic [1:0] sb[$];

  sumador_2bits #(.REG_OUT(1'b1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .in_valid(in_valid),
    .S(S), .C(C), .SUM(SUM), .out_valid(out_valid), .carry_cnt(carry_cnt)
  );

  sumador_2bits #(.REG_OUT(1'b0), .CNT_W(8)) dut_comb (
    .clk(clk), .rst(rst), .A(a0), .B(b0), .in_valid(v0),
    .S(s0), .C(c0), .SUM(sum0), .out_valid(ov0), .carry_cnt(cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected value is {C,S}; SUM must equal the same pair.
  task automatic issue(input logic a, input logic b, input logic v, input logic [1:0] exp_cs);
    @(posedge clk);
    #1;
    A        = a;
    B        = b;
    in_valid = v;
    if (v) sb.push_back(exp_cs);
  endtask

  // Monitor: pops one expected entry per valid output.
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          $display("txn: S=%b C=%b SUM=%0d expected C,S=%b cnt=%0d", S, C, SUM, e, carry_cnt);
          check("sb_S", {31'd0, S}, {31'd0, e[0]});
          check("sb_C", {31'd0, C}, {31'd0, e[1]});
          check("sb_SUM", {30'd0, SUM}, {30'd0, e});
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  logic [1:0] ab_t [4];
  logic [1:0] cs_t [4];
  logic       v_t  [4];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ab_t = '{2'b00, 2'b01, 2'b10, 2'b11};
    cs_t = '{2'b00, 2'b01, 2'b01, 2'b10};
    v_t  = '{1'b1, 1'b1, 1'b1, 1'b0};

    rst = 1'b1;
    A = 1'b0; B = 1'b0; in_valid = 1'b0;
    a0 = 1'b0; b0 = 1'b0; v0 = 1'b0;
    #1;
    check("rst_S", {31'd0, S}, 32'd0);
    check("rst_C", {31'd0, C}, 32'd0);
    check("rst_SUM", {30'd0, SUM}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_carry_cnt", {24'd0, carry_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Combinational instance: outputs follow inputs with no clock edge involved.
    for (int i = 0; i < 4; i++) begin
      a0 = ab_t[i][1];
      b0 = ab_t[i][0];
      v0 = v_t[i];
      #1;
      $display("comb txn: A=%b B=%b v=%b -> S=%b C=%b SUM=%0d ov=%b", a0, b0, v0, s0, c0, sum0, ov0);
      check("comb_S", {31'd0, s0}, {31'd0, cs_t[i][0]});
      check("comb_C", {31'd0, c0}, {31'd0, cs_t[i][1]});
      check("comb_SUM", {30'd0, sum0}, {30'd0, cs_t[i]});
      check("comb_out_valid", {31'd0, ov0}, {31'd0, v_t[i]});
      #4;
    end
    @(posedge clk);
    #1 a0 = 1'b1; b0 = 1'b1; v0 = 1'b1;
    repeat (3) @(posedge clk);
    #1 v0 = 1'b0;
    check("comb_carry_cnt", {24'd0, cnt0}, 32'd3);

    // Exhaustive truth table through the registered path.
    for (int i = 0; i < 4; i++) issue(ab_t[i][1], ab_t[i][0], 1'b1, cs_t[i]);

    // Hold: invalid 11 after a 01 sample must leave S=1,C=0 with out_valid low.
    issue(1'b0, 1'b1, 1'b1, 2'b01);
    issue(1'b1, 1'b1, 1'b0, 2'b00);
    @(posedge clk);
    @(negedge clk);
    check("hold_S", {31'd0, S}, 32'd1);
    check("hold_C", {31'd0, C}, 32'd0);
    check("hold_out_valid", {31'd0, out_valid}, 32'd0);
    check("hold_carry_cnt", {24'd0, carry_cnt}, 32'd1);

    // Build up C=1, carry_cnt=5, then assert reset between clock edges.
    repeat (4) issue(1'b1, 1'b1, 1'b1, 2'b10);
    issue(1'b0, 1'b0, 1'b0, 2'b00);
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_C", {31'd0, C}, 32'd1);
    check("pre_rst_carry_cnt", {24'd0, carry_cnt}, 32'd5);
    #1 rst = 1'b1;
    #1;
    check("async_rst_S", {31'd0, S}, 32'd0);
    check("async_rst_C", {31'd0, C}, 32'd0);
    check("async_rst_SUM", {30'd0, SUM}, 32'd0);
    check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_carry_cnt", {24'd0, carry_cnt}, 32'd0);
    A = 1'b1; B = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_release_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_release_carry_cnt", {24'd0, carry_cnt}, 32'd0);

    // Saturation: 300 carries into an 8-bit counter.
    repeat (300) issue(1'b1, 1'b1, 1'b1, 2'b10);
    issue(1'b0, 1'b0, 1'b0, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("sat_carry_cnt", {24'd0, carry_cnt}, 32'd255);
    check("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
